// File: rtl/rv_pkg.sv
// Shared RV32I/RV64I decode definitions: immediate selector encodings,
// skid-buffer states, default XLEN and base opcode constants.
package rv_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b011,
        IMM_U     = 3'b100,
        IMM_Z     = 3'b101,
        IMM_SHAMT = 3'b110,
        IMM_RSVD  = 3'b111
    } imm_sel_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: instruction word + selector -> XLEN imm + err.
// Selector 101 (CSR zimm) is only legal when IMMGEN_ZIMM_EN is defined.
module imm_extract
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // The opcode field never contributes to any immediate.
    logic unused_opc;
    assign unused_opc = ^inst[6:0];

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
        return XLEN'(v);
    endfunction

    always_comb begin
        imm = '0;
        err = 1'b0;
        case (imm_sel_t'(sel))
            IMM_I: imm = sext32({{20{inst[31]}}, inst[31:20]});
            IMM_S: imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
            IMM_B: imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
            IMM_J: imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
            IMM_U: imm = sext32({inst[31:12], 12'b0});
            IMM_Z: begin
`ifdef IMMGEN_ZIMM_EN
                imm = zext6({1'b0, inst[19:15]});
`else
                err = 1'b1;
`endif
            end
            IMM_SHAMT: imm = (XLEN == 64) ? zext6(inst[25:20]) : zext6({1'b0, inst[24:20]});
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry skid buffer on a valid/ready handshake.
// Build option IMMGEN_ZIMM_EN enables the CSR zimm selector (see imm_extract).
module imm_gen_pipe
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    logic [XLEN-1:0]  ext_imm_p0;
    logic             ext_err_p0;
    logic [XLEN-1:0]  skid_imm_p1;
    logic [TAG_W-1:0] skid_tag_p1;
    logic             skid_err_p1;
    buf_state_t       state;
    logic             in_fire;
    logic             out_fire;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst (in_inst),
        .sel  (in_sel),
        .imm  (ext_imm_p0),
        .err  (ext_err_p0)
    );

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // ---- stage p0 -> p1: main (out_*) and skid entries ----
    // in_ready is registered as "skid will be empty", so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_tag     <= '0;
            out_err     <= 1'b0;
            skid_imm_p1 <= '0;
            skid_tag_p1 <= '0;
            skid_err_p1 <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        out_imm   <= ext_imm_p0;
                        out_tag   <= in_tag;
                        out_err   <= ext_err_p0;
                        out_valid <= 1'b1;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    in_ready <= !(in_fire && !out_fire);
                    if (in_fire && out_fire) begin
                        out_imm <= ext_imm_p0;
                        out_tag <= in_tag;
                        out_err <= ext_err_p0;
                    end else if (in_fire) begin
                        skid_imm_p1 <= ext_imm_p0;
                        skid_tag_p1 <= in_tag;
                        skid_err_p1 <= ext_err_p0;
                        state       <= ST_TWO;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    in_ready <= out_fire;
                    if (out_fire) begin
                        out_imm <= skid_imm_p1;
                        out_tag <= skid_tag_p1;
                        out_err <= skid_err_p1;
                        state   <= ST_ONE;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the RV32I/RV64I decode stage.
- Takes an instruction word plus an immediate-type selector over a valid/ready handshake.
- Produces the sign- or zero-extended XLEN immediate one cycle later, with a 2-entry skid buffer so backpressure never drops or duplicates a beat.
- Adds SHAMT extraction, an illegal-selector flag and XLEN generalisation.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag carried alongside each beat (e.g. rd or ROB index).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_inst  in  32  instruction word.
- in_sel  in  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR zimm), 110 SHAMT, 111 reserved.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_imm  out  XLEN  generated immediate.
- out_tag  out  TAG_W  tag of the output beat.
- out_err  out  1  beat used an illegal or unsupported selector.

Behaviour:
- Reset is asynchronous, active-low. While rst_n is low:
  - out_valid=0, out_imm=0, out_tag=0, out_err=0.
  - Both buffer entries are empty.
  - in_ready=0 while in reset; it goes to 1 on the first clock edge after release.
- Transfers: an input transfer occurs when in_valid&&in_ready at a rising edge; an output transfer occurs when out_valid&&out_ready.
- Latency: a beat accepted at edge N is presented at out_* after edge N when the buffer was empty.
- Storage: two entries, main (drives out_*) and skid.
  - in_ready = !skid_full, taken from a register, with no combinational path from out_ready.
- States: EMPTY, ONE (main full), TWO (main+skid full).
  - EMPTY + input transfer -> ONE.
  - ONE + input and output transfer together -> ONE; main is reloaded with the new beat.
  - ONE + input only -> TWO.
  - ONE + output only -> EMPTY.
  - TWO + output transfer -> ONE; skid moves to main. in_ready is 0 in TWO, so no input is accepted.
- Ordering is strictly FIFO; no beat is lost or duplicated under any out_ready pattern.
- Immediate formation (computed before registering; sign bit s = inst[31]):
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - U: sext({inst[31:12], 12'b0}); for XLEN=64 bits 63:32 copy inst[31].
  - SHAMT: zext(inst[24:20]) when XLEN=32; zext(inst[25:20]) when XLEN=64.
  - Z: see Optional Feature.
  - 111: imm=0, out_err=1.
- out_err is registered together with imm and tag as one beat.
- The data path accepts any in_inst value; no opcode checking.
- When in_valid is low, in_* values are ignored.
- Reset asserted mid-stream empties the buffer immediately; in-flight beats are discarded.

Optional Feature:
- Macro: IMMGEN_ZIMM_EN.
- Defined: sel 101 yields zext(inst[19:15]) (CSR uimm), out_err=0.
- Undefined: sel 101 is treated as reserved, giving imm=0 and out_err=1.
- The handshake is identical in both builds.

Decomposition:
- Shared package rv_pkg holds:
  - the imm_sel_t encodings (IMM_I..IMM_RSVD);
  - the XLEN default;
  - the ISA opcode constants.
- One sub-module, imm_extract: purely combinational, inst+sel -> imm+err, parametrised by XLEN.
- imm_gen_pipe holds the skid-buffer control and storage.

Test Plan:
1. XLEN=32, out_ready=1. Input sel=I, inst=0xFFF00093 -> out_imm=0xFFFFFFFF one cycle later, out_err=0.
2. sel=B, inst=0xFE000EE3 -> 0xFFFFFFFC. sel=S, inst=0xFE000C23 -> 0xFFFFFFF8.
3. sel=J, inst=0x0010006F -> 0x00000800 (checks inst[20] placement). sel=U, inst=0x123450B7 -> 0x12345000; with XLEN=64, inst=0x800000B7 -> 0xFFFFFFFF80000000.
4. Backpressure: hold out_ready=0 and send 3 beats with tags 1,2,3 -> exactly 2 accepted, in_ready drops after the second. Then set out_ready=1 -> tags 1,2,3 appear in order, no duplicates.
5. sel=111 -> out_imm=0, out_err=1. sel=101, inst=0x000FD073 -> 0x0000001F with IMMGEN_ZIMM_EN defined; imm=0 and out_err=1 without it.
6. Pull rst_n low while the buffer is in state TWO -> out_valid=0 immediately, with no clock edge. After release, a new beat (tag 7) is the first and only output.
